bist_ctrl: RTL
==============

Name: bist_ctrl

Overview:
Built-in self-test sequencer for the 4-requester grant arbiter and its 16-bit grant-compaction MISR.
- On request, takes over the arbiter request inputs with an 8-bit LFSR pattern generator.
- Holds arbiter and MISR in reset for initialisation, then runs a fixed number of patterns and flushes the pipeline.
- Captures the MISR signature, compares it with a golden value and reports pass/fail.
- Sits beside the arbiter/MISR pair. Owns the test-mode request mux select and the MISR reset.

Parameters:
NBIT, 16, signature width (must match MISR).
PAT_CNT, 1000, number of RUN cycles (patterns applied), 1..65535.
INIT_CYC, 2, cycles arbiter/MISR reset is held in INIT, 1..15.
FLUSH_CYC, 2, cycles of zero requests after RUN for grant/MISR latency, 0..15.
TPG_SEED, 8'hA5, LFSR seed; a zero seed is replaced by 8'h01.
GOLDEN, 16'h0000, expected signature (from reference model).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
bist_start  in  1  level request to start self-test
signature  in  NBIT  MISR signature
test_mode  out  1  selects tpg_req onto arbiter request inputs
tpg_req  out  4  generated request pattern
arb_rst  out  1  arbiter reset during test init
misr_rst  out  1  MISR synchronous reset (loads seed)
bist_busy  out  1  test in progress
bist_done  out  1  result valid
bist_pass  out  1  signature matched GOLDEN
sig_cap  out  NBIT  captured signature
sig_sdo  out  1  serial signature dump data (optional feature)
sig_sdv  out  1  serial dump valid (optional feature)

Behaviour:
- Reset (async): state=IDLE, lfsr=TPG_SEED (or 8'h01), counters 0. All outputs 0 except misr_rst=1.
- States: IDLE, INIT, RUN, FLUSH, COMPARE, [DUMP], DONE.
- IDLE: misr_rst=1. bist_start=1 sampled at an edge moves to INIT; bist_pass, bist_done and sig_cap are cleared.
- INIT: test_mode=1, arb_rst=1, misr_rst=1, bist_busy=1, tpg_req=0. Lasts INIT_CYC cycles, then RUN. lfsr reloads seed.
- RUN: test_mode=1, arb_rst=0, misr_rst=0, tpg_req=lfsr[3:0]. Lasts exactly PAT_CNT cycles.
  - lfsr advances each RUN cycle: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - First RUN cycle presents seed[3:0].
- FLUSH: tpg_req=0, test_mode=1, misr_rst=0. Lasts FLUSH_CYC cycles (0 means skip directly to COMPARE).
- COMPARE: one cycle. At its ending edge: sig_cap<=signature, bist_pass<=(signature==GOLDEN). Next state is DONE, or DUMP when the feature is enabled.
- DONE: bist_done=1, bist_busy=0, test_mode=0, misr_rst=1. Results held. Returns to IDLE when bist_start=0; bist_done clears in IDLE while bist_pass and sig_cap are held.
- bist_start is ignored outside IDLE and DONE. Restart requires a 0 then a 1.
- Latency with defaults: bist_done rises INIT_CYC+PAT_CNT+FLUSH_CYC+1 edges after the edge sampling bist_start.
- Counters are 16-bit, compared against PARAM-1. No wrap occurs.
- Reset mid-operation: immediate return to IDLE with reset values; no partial result is reported.

Optional Feature:
BIST_SIGDUMP_EN
- Defined: after COMPARE, state DUMP shifts sig_cap MSB-first on sig_sdo with sig_sdv=1 for exactly NBIT cycles, then enters DONE. bist_busy stays 1 during DUMP.
- Undefined: COMPARE goes straight to DONE; sig_sdo=0 and sig_sdv=0 constantly.

Test Plan:
- Reset check: assert rst mid-cycle, no clock → misr_rst=1; all other outputs 0; state IDLE.
- PAT_CNT=8, INIT_CYC=2, FLUSH_CYC=2, seed 8'hA5, bist_start pulse:
  - tpg_req sequence 5, A, ... per LFSR equation.
  - bist_done rises 13 edges after the sampling edge.
  - test_mode high for 12 cycles.
- GOLDEN set to the model signature → bist_pass=1 and sig_cap equal to GOLDEN. GOLDEN^16'h0001 → bist_pass=0 with the same sig_cap.
- bist_start held high through DONE → no restart. Drop to 0 then raise again → second run yields an identical sig_cap.
- Assert rst during RUN cycle 4 → immediate IDLE, bist_busy=0, bist_done=0. A subsequent full run passes.
- With BIST_SIGDUMP_EN: sig_sdv high 16 cycles and sig_sdo reproduces sig_cap MSB-first. bist_done is delayed by 16 cycles versus no-macro build.

Source files
------------

// File: rtl/bist_ctrl.sv
// BIST sequencer for the 4-requester arbiter and its grant-compaction MISR.
// Optional serial signature dump is enabled by defining BIST_SIGDUMP_EN.
module bist_ctrl #(
    parameter int unsigned      NBIT      = 16,
    parameter int unsigned      PAT_CNT   = 1000,
    parameter int unsigned      INIT_CYC  = 2,
    parameter int unsigned      FLUSH_CYC = 2,
    parameter logic [7:0]       TPG_SEED  = 8'hA5,
    parameter logic [NBIT-1:0]  GOLDEN    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bist_start,
    input  logic [NBIT-1:0] signature,
    output logic            test_mode,
    output logic [3:0]      tpg_req,
    output logic            arb_rst,
    output logic            misr_rst,
    output logic            bist_busy,
    output logic            bist_done,
    output logic            bist_pass,
    output logic [NBIT-1:0] sig_cap,
    output logic            sig_sdo,
    output logic            sig_sdv
);

    typedef enum logic [2:0] {
        StIdle, StInit, StRun, StFlush, StCompare, StDump, StDone
    } state_e;

    localparam logic [7:0]  Seed      = (TPG_SEED == 8'h00) ? 8'h01 : TPG_SEED;
    localparam logic [15:0] InitLast  = 16'(INIT_CYC - 1);
    localparam logic [15:0] PatLast   = 16'(PAT_CNT - 1);
    localparam logic [15:0] FlushLast = (FLUSH_CYC == 0) ? 16'd0 : 16'(FLUSH_CYC - 1);

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [3:0]  tpg_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        tpg_d   = 4'h0;
        unique case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
                if (bist_start) state_d = StInit;
            end
            StInit: begin
                lfsr_d = Seed;
                if (cnt_q == InitLast) begin
                    // Pattern 0 goes out on the first RUN cycle; lfsr then holds pattern 1.
                    state_d = StRun;
                    cnt_d   = 16'd0;
                    tpg_d   = Seed[3:0];
                    lfsr_d  = lfsr_next(Seed);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRun: begin
                if (cnt_q == PatLast) begin
                    state_d = (FLUSH_CYC == 0) ? StCompare : StFlush;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d  = cnt_q + 16'd1;
                    tpg_d  = lfsr_q[3:0];
                    lfsr_d = lfsr_next(lfsr_q);
                end
            end
            StFlush: begin
                if (cnt_q == FlushLast) begin
                    state_d = StCompare;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCompare: begin
                cnt_d = 16'd0;
`ifdef BIST_SIGDUMP_EN
                state_d = StDump;
`else
                state_d = StDone;
`endif
            end
`ifdef BIST_SIGDUMP_EN
            StDump: begin
                if (cnt_q == 16'(NBIT - 1)) begin
                    state_d = StDone;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            StDone: begin
                if (!bist_start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            lfsr_q    <= Seed;
            test_mode <= 1'b0;
            tpg_req   <= 4'h0;
            arb_rst   <= 1'b0;
            misr_rst  <= 1'b1;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
            bist_pass <= 1'b0;
            sig_cap   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            tpg_req   <= tpg_d;
            test_mode <= (state_d == StInit) || (state_d == StRun) || (state_d == StFlush);
            arb_rst   <= (state_d == StInit);
            misr_rst  <= (state_d == StIdle) || (state_d == StInit) || (state_d == StDone);
            bist_busy <= (state_d != StIdle) && (state_d != StDone);
            bist_done <= (state_d == StDone);
            if (state_q == StIdle && state_d == StInit) begin
                bist_pass <= 1'b0;
                sig_cap   <= '0;
            end else if (state_q == StCompare) begin
                bist_pass <= (signature == GOLDEN);
                sig_cap   <= signature;
            end
        end
    end

`ifdef BIST_SIGDUMP_EN
    logic [NBIT-1:0] sh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            sig_sdo <= 1'b0;
            sig_sdv <= 1'b0;
        end else begin
            sh_q    <= (state_q == StCompare) ? (signature << 1) : (sh_q << 1);
            sig_sdv <= (state_d == StDump);
            if (state_d == StDump)
                sig_sdo <= (state_q == StCompare) ? signature[NBIT-1] : sh_q[NBIT-1];
            else
                sig_sdo <= 1'b0;
        end
    end
`else
    assign sig_sdo = 1'b0;
    assign sig_sdv = 1'b0;
`endif

endmodule
